// File: rtl/interrupt_pulse_ctrl.sv
// ---------------------------------------------------------------------------
// interrupt_pulse_ctrl
//
// Multi-channel interrupt pulse generator. Rising edges on the REQ lines are
// latched into per-channel pending bits. Unmasked pending channels are
// arbitrated by fixed priority, where index 0 is the highest priority. Each
// serviced request produces one INTERRUPT pulse that is PULSE_W cycles wide.
// Pulses are separated by GAP_W forced-low cycles. INT_ID carries the index
// of the serviced channel.
//
// Ports
//   clk        system clock; all state updates on the rising edge
//   RST        asynchronous active-high reset
//   REQ        level request lines, one per channel
//   MASK       1 = channel may win arbitration (sampled only while idle)
//   CLR        synchronous clear of PENDING and OVERRUN
//   INTERRUPT  interrupt pulse to the CPU
//   INT_ID     index of the channel being / last serviced
//   BUSY       high while a pulse or its trailing gap is in progress
//   PENDING    latched, unserviced request edges
//   OVERRUN    sticky: an edge arrived while that channel was still pending
// ---------------------------------------------------------------------------
module interrupt_pulse_ctrl #(
    parameter int  NUM_CH  = 4,
    parameter int  PULSE_W = 6,
    parameter int  GAP_W   = 2,
    localparam int ID_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [NUM_CH-1:0] REQ,
    input  logic [NUM_CH-1:0] MASK,
    input  logic              CLR,
    output logic              INTERRUPT,
    output logic [ID_W-1:0]   INT_ID,
    output logic              BUSY,
    output logic [NUM_CH-1:0] PENDING,
    output logic [NUM_CH-1:0] OVERRUN
);

    // One down-counter is shared by the pulse phase and the gap phase.
    // It is sized for the longer of the two phases.
    localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_W > 0) ? CNT_W'(GAP_W - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              int_reg;
    logic              busy_reg;
    logic [ID_W-1:0]   id_reg;
    logic [NUM_CH-1:0] req_reg;
    logic [NUM_CH-1:0] pending_reg;
    logic [NUM_CH-1:0] pending_next;
    logic [NUM_CH-1:0] overrun_reg;
    logic [NUM_CH-1:0] overrun_next;

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] svc_clr;
    logic [ID_W-1:0]   sel_idx;
    logic              do_select;

    // Arbitration. sel & -sel isolates the lowest set bit, so grant is one-hot
    // on the highest-priority candidate.
    assign sel       = pending_reg & MASK;
    assign grant     = sel & (~sel + NUM_CH'(1));
    assign do_select = (state_reg == IDLE) && (|sel);
    assign svc_clr   = do_select ? grant : '0;

    always_comb begin
        sel_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (sel[i]) begin
                sel_idx = ID_W'(i);
            end
        end
    end

    // Per-channel edge detect and pending/overrun update.
    // Priority: CLR > new edge > service clear.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign rise[gi] = REQ[gi] & ~req_reg[gi];

            assign pending_next[gi] = CLR          ? 1'b0 :
                                      rise[gi]     ? 1'b1 :
                                      svc_clr[gi]  ? 1'b0 :
                                                     pending_reg[gi];

            // An edge that lands on a bit being serviced in this same cycle
            // simply re-pends the channel. It is not an overrun.
            assign overrun_next[gi] = CLR ? 1'b0 :
                                      (overrun_reg[gi] |
                                       (rise[gi] & pending_reg[gi] & ~svc_clr[gi]));
        end
    endgenerate

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            req_reg     <= '0;
            pending_reg <= '0;
            overrun_reg <= '0;
        end else begin
            req_reg     <= REQ;
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
        end
    end

    // Pulse sequencer. INTERRUPT and BUSY are registered alongside the state.
    // This keeps them glitch-free and exactly aligned with PULSE and GAP.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            int_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            id_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (do_select) begin
                        id_reg    <= sel_idx;
                        cnt_reg   <= PULSE_LOAD;
                        state_reg <= PULSE;
                        int_reg   <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_reg == '0) begin
                        int_reg <= 1'b0;
                        cnt_reg <= GAP_LOAD;
                        if (GAP_W == 0) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= GAP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    // Unused encoding: recover to IDLE with the output low.
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    int_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign INTERRUPT = int_reg;
    assign INT_ID    = id_reg;
    assign BUSY      = busy_reg;
    assign PENDING   = pending_reg;
    assign OVERRUN   = overrun_reg;

endmodule

// File: tb/tb_interrupt_pulse_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for interrupt_pulse_ctrl (NUM_CH=4, PULSE_W=6, GAP_W=2).
//
// Test structure:
//   - A table of per-cycle vectors covers the single-edge case.
//   - Hand-written sequences cover the multi-cycle corner cases.
//   - A randomized phase runs last.
//
// A reference model runs in parallel and is compared on every falling edge.
// The model tracks the sequencer only as "cycles left until idle". The pulse
// is high while that count exceeds GAP_W.
// ---------------------------------------------------------------------------
module tb_interrupt_pulse_ctrl;

    localparam int NUM_CH  = 4;
    localparam int PULSE_W = 6;
    localparam int GAP_W   = 2;

    logic       clk  = 1'b0;
    logic       RST  = 1'b0;
    logic [3:0] REQ  = 4'h0;
    logic [3:0] MASK = 4'hF;
    logic       CLR  = 1'b0;
    logic       INTERRUPT;
    logic [1:0] INT_ID;
    logic       BUSY;
    logic [3:0] PENDING;
    logic [3:0] OVERRUN;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    interrupt_pulse_ctrl #(
        .NUM_CH  (NUM_CH),
        .PULSE_W (PULSE_W),
        .GAP_W   (GAP_W)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .REQ       (REQ),
        .MASK      (MASK),
        .CLR       (CLR),
        .INTERRUPT (INTERRUPT),
        .INT_ID    (INT_ID),
        .BUSY      (BUSY),
        .PENDING   (PENDING),
        .OVERRUN   (OVERRUN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        REQ = 4'h0;
        CLR = 1'b0;
        repeat (n) cyc();
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0] pend;
        logic [3:0] ovr;
        int         id;
        int         left;   // cycles until the sequencer is idle again
    } mstate_t;

    function automatic mstate_t mnext(input mstate_t s, input logic [3:0] req,
                                      input logic [3:0] prev, input logic [3:0] mask,
                                      input logic clr);
        mstate_t    n;
        logic [3:0] rise;
        logic [3:0] sel;
        logic [3:0] svc;
        int         k;
        n    = s;
        rise = req & ~prev;
        sel  = s.pend & mask;
        svc  = 4'h0;
        k    = 0;
        if (s.left == 0) begin
            if (sel != 4'h0) begin
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (sel[i]) k = i;
                end
                svc[k] = 1'b1;
                n.id   = k;
                n.left = PULSE_W + GAP_W;
            end
        end else begin
            n.left = s.left - 1;
        end
        n.ovr  = clr ? 4'h0 : (s.ovr | (rise & s.pend & ~svc));
        n.pend = clr ? 4'h0 : ((s.pend & ~svc) | rise);
        return n;
    endfunction

    mstate_t    m;
    logic [3:0] m_prev;

    always @(posedge clk or posedge RST) begin
        if (RST) begin
            m      <= '{4'h0, 4'h0, 0, 0};
            m_prev <= 4'h0;
        end else begin
            m      <= mnext(m, REQ, m_prev, MASK, CLR);
            m_prev <= REQ;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("model_interrupt", INTERRUPT, (m.left > GAP_W));
            chk("model_busy",      BUSY,      (m.left > 0));
            chk("model_int_id",    INT_ID,    m.id);
            chk("model_pending",   PENDING,   m.pend);
            chk("model_overrun",   OVERRUN,   m.ovr);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] req;
        logic [3:0] mask;
        logic       clr;
        logic       intr;
        logic [1:0] id;
        logic       busy;
        logic [3:0] pend;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Single edge on channel 2, held high: one pulse, E1..E7.
        tbl[0] = '{4'b0100, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0100};
        tbl[1] = '{4'b0100, 4'hF, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
        for (int r = 2; r <= 6; r++) tbl[r] = '{4'b0100, 4'hF, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
        tbl[7]  = '{4'b0100, 4'hF, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[8]  = '{4'b0100, 4'hF, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[9]  = '{4'b0100, 4'hF, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000};
        tbl[10] = '{4'b0100, 4'hF, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000};

        #1 RST = 1'b1;
        mon_en = 1'b1;
        cyc();
        chk("reset_interrupt", INTERRUPT, 1'b0);
        chk("reset_int_id",    INT_ID,    2'd0);
        chk("reset_busy",      BUSY,      1'b0);
        chk("reset_pending",   PENDING,   4'h0);
        chk("reset_overrun",   OVERRUN,   4'h0);
        @(posedge clk);
        #1 RST = 1'b0;

        for (int r = 0; r < 11; r++) begin
            REQ  = tbl[r].req;
            MASK = tbl[r].mask;
            CLR  = tbl[r].clr;
            cyc();
            chk($sformatf("vec%0d_interrupt", r), INTERRUPT, tbl[r].intr);
            chk($sformatf("vec%0d_int_id", r),    INT_ID,    tbl[r].id);
            chk($sformatf("vec%0d_busy", r),      BUSY,      tbl[r].busy);
            chk($sformatf("vec%0d_pending", r),   PENDING,   tbl[r].pend);
        end
        repeat (10) begin
            cyc();
            chk("held_req_single_pulse", INTERRUPT, 1'b0);
        end
        idle(3);

        // Simultaneous edges on channels 1 and 3.
        REQ = 4'b1010;
        cyc();
        chk("simul_pending", PENDING, 4'b1010);
        repeat (6) begin
            cyc();
            chk("simul_first_high", INTERRUPT, 1'b1);
            chk("simul_first_id",   INT_ID,    2'd1);
        end
        repeat (3) begin
            cyc();
            chk("simul_gap_low", INTERRUPT, 1'b0);
        end
        repeat (6) begin
            cyc();
            chk("simul_second_high", INTERRUPT, 1'b1);
            chk("simul_second_id",   INT_ID,    2'd3);
        end
        cyc();
        chk("simul_end_low",     INTERRUPT, 1'b0);
        chk("simul_end_pending", PENDING,   4'h0);
        idle(5);

        // Masked channel 0 stays pending until unmasked.
        MASK = 4'b1110;
        REQ  = 4'b0001;
        cyc();
        chk("mask_pending", PENDING, 4'b0001);
        REQ = 4'b0000;
        repeat (10) begin
            cyc();
            chk("mask_no_interrupt", INTERRUPT, 1'b0);
            chk("mask_still_pending", PENDING, 4'b0001);
        end
        MASK = 4'hF;
        cyc();
        chk("unmask_interrupt", INTERRUPT, 1'b1);
        chk("unmask_int_id",    INT_ID,    2'd0);
        idle(10);

        // Overrun on channel 3, then CLR.
        MASK = 4'h0;
        REQ  = 4'b1000;
        cyc();
        REQ = 4'b0000;
        cyc();
        REQ = 4'b1000;
        cyc();
        chk("overrun_set",     OVERRUN, 4'b1000);
        chk("overrun_pending", PENDING, 4'b1000);
        REQ = 4'b0000;
        CLR = 1'b1;
        cyc();
        CLR = 1'b0;
        chk("clr_pending", PENDING, 4'h0);
        chk("clr_overrun", OVERRUN, 4'h0);
        repeat (5) begin
            cyc();
            chk("clr_no_pulse", INTERRUPT, 1'b0);
        end
        MASK = 4'hF;
        idle(2);

        // Re-arm channel 1 during its own pulse.
        REQ = 4'b0010;
        cyc();
        REQ = 4'b0000;
        cyc();
        chk("rearm_first_high", INTERRUPT, 1'b1);
        chk("rearm_first_id",   INT_ID,    2'd1);
        REQ = 4'b0010;
        cyc();
        chk("rearm_pending", PENDING, 4'b0010);
        chk("rearm_overrun", OVERRUN, 4'b0000);
        REQ = 4'b0000;
        repeat (6) cyc();
        cyc();
        chk("rearm_idle_low", INTERRUPT, 1'b0);
        cyc();
        chk("rearm_second_high", INTERRUPT, 1'b1);
        chk("rearm_second_id",   INT_ID,    2'd1);
        chk("rearm_no_overrun",  OVERRUN,   4'b0000);
        idle(10);

        // Asynchronous reset in the 3rd pulse cycle.
        REQ = 4'b0001;
        cyc();
        cyc();
        cyc();
        cyc();
        chk("rst_pre_high", INTERRUPT, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("rst_async_interrupt", INTERRUPT, 1'b0);
        chk("rst_async_busy",      BUSY,      1'b0);
        chk("rst_async_id",        INT_ID,    2'd0);
        chk("rst_async_pending",   PENDING,   4'h0);
        chk("rst_async_overrun",   OVERRUN,   4'h0);
        RST = 1'b0;
        cyc();
        chk("rst_rel_clk1_low",     INTERRUPT, 1'b0);
        chk("rst_rel_clk1_pending", PENDING,   4'b0001);
        cyc();
        chk("rst_rel_clk2_high", INTERRUPT, 1'b1);
        chk("rst_rel_clk2_id",   INT_ID,    2'd0);
        idle(12);

        // Randomized traffic, checked by the model each cycle.
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < NUM_CH; b++) begin
                if ($urandom_range(3) == 0) REQ[b] = ~REQ[b];
            end
            if ($urandom_range(15) == 0) MASK = 4'($urandom_range(15));
            CLR = ($urandom_range(31) == 0);
            cyc();
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interrupt_pulse_ctrl.md
Name: interrupt_pulse_ctrl

Overview:
- Parametrised multi-channel interrupt pulse generator.
- Detects rising edges on NUM_CH request lines and latches each into a per-channel pending bit.
- Arbitrates among unmasked pending channels by fixed priority and issues one fixed-width INTERRUPT pulse per serviced request, tagged with the channel ID.
- Sits between peripheral/board request sources and the CPU interrupt input; replaces single-channel pulse generation.

Parameters:
- NUM_CH, 4, number of request channels (1..16).
- PULSE_W, 6, INTERRUPT high time in clk cycles (>=1).
- GAP_W, 2, minimum INTERRUPT low cycles between consecutive pulses (>=0).
- ID_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), width of INT_ID; derived, not overridden.

Ports:
- clk  in  1  system clock; all state on rising edge.
- RST  in  1  asynchronous active-high reset.
- REQ  in  NUM_CH  level request lines, one per channel, synchronous to clk.
- MASK  in  NUM_CH  1 = channel enabled for arbitration.
- CLR  in  1  synchronous clear of PENDING and OVERRUN.
- INTERRUPT  out  1  interrupt pulse to CPU.
- INT_ID  out  ID_W  index of channel being/last serviced.
- BUSY  out  1  high while in PULSE or GAP.
- PENDING  out  NUM_CH  latched, unserviced edges.
- OVERRUN  out  NUM_CH  sticky: edge arrived while already pending.

Behaviour:
- Reset (async, RST=1):
  - PS=IDLE, INTERRUPT=0, INT_ID=0, BUSY=0.
  - PENDING=0, OVERRUN=0.
  - REQ_q=0, counter=0.
  - On release, any REQ already high is seen as an edge on the first clk.
- Edge detect:
  - REQ_q <= REQ every cycle.
  - rise[i] = REQ[i] & ~REQ_q[i].
  - A held-high REQ produces exactly one edge. It must go low for at least 1 cycle to re-arm.
- PENDING[i], per edge, in priority order:
  - CLR=1 -> 0 (CLR beats a same-cycle edge).
  - else rise[i] -> 1 (set beats same-cycle service clear).
  - else service of channel i -> 0.
  - Mask does not block setting PENDING.
- OVERRUN[i]:
  - Set when rise[i] and PENDING[i]=1 and that pending bit is not being cleared by service in the same cycle.
  - Cleared only by CLR or RST.
- FSM states: IDLE, PULSE, GAP.
- IDLE:
  - Let sel = PENDING & MASK.
  - If sel != 0: choose the lowest set index k (index 0 = highest priority); INT_ID <= k; clear PENDING[k]; cnt <= PULSE_W-1; PS <= PULSE.
  - Else remain in IDLE.
  - MASK is sampled only here; changes during PULSE/GAP affect the next arbitration only.
- PULSE:
  - INTERRUPT=1, decoded from state register (glitch-free).
  - If cnt==0: PS <= (GAP_W==0 ? IDLE : GAP), cnt <= GAP_W-1.
  - Else cnt <= cnt-1.
- GAP:
  - INTERRUPT=0.
  - If cnt==0: PS <= IDLE; else cnt <= cnt-1.
- Timing:
  - INTERRUPT is high for exactly PULSE_W consecutive cycles per service.
  - Pulses are separated by at least GAP_W+1 low cycles (GAP_W gap cycles plus the IDLE arbitration cycle).
  - Latency: REQ high before edge E0 -> PENDING set at E0 -> selected at E1 -> INTERRUPT high from E1 for PULSE_W cycles.
- INT_ID updates only at selection and holds through PULSE, GAP and IDLE until the next selection.
- BUSY = (PS != IDLE).
- CLR does not abort a pulse in progress.
- RST mid-pulse drops INTERRUPT immediately (async) and discards all pending requests.
- Illegal/unused state encoding -> IDLE next cycle, INTERRUPT=0.

Test Plan:
- Single edge, NUM_CH=4, PULSE_W=6, GAP_W=2:
  - Stimulus: REQ[2] rises before E0 and is held high 20 cycles, MASK=4'hF.
  - Required: INTERRUPT high E1..E7 (6 cycles), INT_ID=2, exactly one pulse, PENDING=0 afterwards.
- Simultaneous edges:
  - Stimulus: REQ=4'b1010 rises at E0.
  - Required: first pulse INT_ID=1, then 3 low cycles, second pulse INT_ID=3; total 2 pulses of 6 cycles each.
- Masked channel:
  - Stimulus: MASK=4'b1110, REQ[0] pulses.
  - Required: PENDING[0]=1 with no INTERRUPT for 10 cycles.
  - Then set MASK[0]=1: pulse with INT_ID=0 starts one cycle after the MASK edge.
- Overrun:
  - Stimulus: MASK=0, REQ[3] toggles high-low-high.
  - Required: OVERRUN[3]=1, PENDING[3]=1.
  - Then CLR for 1 cycle: both 0, no pulse issued.
- Re-arm during pulse:
  - Stimulus: REQ[1] edge, then a low cycle and a second edge during the first pulse.
  - Required: second pulse follows after the gap, OVERRUN[1]=0.
- Reset mid-pulse:
  - Stimulus: assert RST asynchronously in the 3rd PULSE cycle.
  - Required: INTERRUPT=0 before the next clk, and all outputs at reset values.
  - After release with REQ[0] still high: one pulse INT_ID=0 starting on the 2nd clk.
